// File: rtl/clarke_transform.sv
// -----------------------------------------------------------------------------
// clarke_transform
//   Fixed-point Clarke transform (abc -> alpha/beta) for a balanced three-phase
//   system, where c = -a - b is implied:
//       alpha = a
//       beta  = (a + 2b) / sqrt(3)
//   The block is fully pipelined. It accepts one sample per clock and has
//   three register stages. It has no stall and no backpressure.
//
// Parameters
//   D_WIDTH  signed width of a, b, alpha and beta (two's complement)
//   Q_BITS   fractional bits of all data; 1.0 = 2**Q_BITS
//
// Ports
//   clk    in   1        clock; all logic runs on the rising edge
//   rstb   in   1        asynchronous, active-low reset
//   a      in   D_WIDTH  phase-a sample
//   b      in   D_WIDTH  phase-b sample
//   start  in   1        input-valid strobe; a and b are sampled when it is high
//   alpha  out  D_WIDTH  alpha result; holds the last valid value
//   beta   out  D_WIDTH  beta result; holds the last valid value
//   done   out  1        output-valid strobe, three edges after start
// -----------------------------------------------------------------------------
module clarke_transform #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic signed [D_WIDTH-1:0]  a,
    input  logic signed [D_WIDTH-1:0]  b,
    input  logic                       start,
    output logic signed [D_WIDTH-1:0]  alpha,
    output logic signed [D_WIDTH-1:0]  beta,
    output logic                       done
);

    localparam int SW = D_WIDTH + 2;   // width of a + 2b
    localparam int KW = Q_BITS + 2;    // signed width of the 1/sqrt(3) coefficient
    localparam int PW = SW + KW;       // full product width

    // Computes K = round(2**q / sqrt(3)) using integer arithmetic only.
    // K is the largest k for which 3*(2k-1)^2 <= 4^(q+1).
    // This condition is the same as (k - 0.5) <= 2**q / sqrt(3).
    function automatic longint unsigned calc_k(input int q);
        longint unsigned k;
        longint unsigned t;
        longint unsigned d;
        longint unsigned lim;
        k   = 64'd0;
        lim = 64'd1 << (2 * q + 2);
        for (int bi = q; bi >= 0; bi--) begin
            t = k | (64'd1 << bi);
            d = 2 * t - 64'd1;
            if (3 * d * d <= lim) begin
                k = t;
            end
        end
        return k;
    endfunction

    localparam longint unsigned  K_VAL  = calc_k(Q_BITS);
    localparam logic signed [KW-1:0] K_COEF = $signed(K_VAL[KW-1:0]);

    localparam logic signed [PW-1:0] MAX_P =
        $signed({{(PW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] MIN_P =
        $signed({{(PW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}});

    // Adds one half LSB, then shifts arithmetically.
    // The result is round-half-up, so an exact .5 moves toward +infinity.
    function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] half;
        half             = '0;
        half[Q_BITS-1]   = 1'b1;
        return (p + half) >>> Q_BITS;
    endfunction

    // Clamps a value to the signed D_WIDTH output range.
    function automatic logic signed [D_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] c;
        if (v > MAX_P) begin
            c = MAX_P;
        end else if (v < MIN_P) begin
            c = MIN_P;
        end else begin
            c = v;
        end
        return c[D_WIDTH-1:0];
    endfunction

    logic signed [SW-1:0]       w_sum;
    logic signed [PW-1:0]       w_prod;
    logic signed [D_WIDTH-1:0]  w_beta;

    logic signed [D_WIDTH-1:0]  r_alpha_p1;
    logic signed [SW-1:0]       r_sum_p1;
    logic                       r_vld_p1;

    logic signed [D_WIDTH-1:0]  r_alpha_p2;
    logic signed [PW-1:0]       r_prod_p2;
    logic                       r_vld_p2;

    logic signed [D_WIDTH-1:0]  r_alpha_p3;
    logic signed [D_WIDTH-1:0]  r_beta_p3;
    logic                       r_vld_p3;

    // Both addends are sign-extended to SW bits, so a + 2b cannot overflow.
    assign w_sum = $signed({{2{a[D_WIDTH-1]}}, a}) + $signed({b[D_WIDTH-1], b, 1'b0});

    // Both operands are extended to the product width before multiplying.
    // The exact product fits in PW bits, so the truncated result is exact.
    assign w_prod = $signed({{KW{r_sum_p1[SW-1]}}, r_sum_p1})
                  * $signed({{SW{K_COEF[KW-1]}}, K_COEF});

    assign w_beta = sat(round_shift(r_prod_p2));

    // ---- Stage 1: capture alpha and form a + 2b ----
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_vld_p1   <= 1'b0;
            r_alpha_p1 <= '0;
            r_sum_p1   <= '0;
        end else begin
            r_vld_p1 <= start;
            if (start) begin
                r_alpha_p1 <= a;
                r_sum_p1   <= w_sum;
            end
        end
    end

    // ---- Stage 2: full-width multiply by 1/sqrt(3) ----
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_vld_p2   <= 1'b0;
            r_alpha_p2 <= '0;
            r_prod_p2  <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_alpha_p2 <= r_alpha_p1;
                r_prod_p2  <= w_prod;
            end
        end
    end

    // ---- Stage 3: round, saturate and register the outputs ----
    // The output registers load only on valid samples.
    // Between valid samples they hold the last result.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_vld_p3   <= 1'b0;
            r_alpha_p3 <= '0;
            r_beta_p3  <= '0;
        end else begin
            r_vld_p3 <= r_vld_p2;
            if (r_vld_p2) begin
                r_alpha_p3 <= r_alpha_p2;
                r_beta_p3  <= w_beta;
            end
        end
    end

    assign alpha = r_alpha_p3;
    assign beta  = r_beta_p3;
    assign done  = r_vld_p3;

endmodule

// File: tb/tb_clarke_transform.sv
module tb_clarke_transform;

    localparam int D_WIDTH = 18;
    localparam int Q_BITS  = 15;

    logic                      clk;
    logic                      rstb;
    logic signed [D_WIDTH-1:0] a;
    logic signed [D_WIDTH-1:0] b;
    logic                      start;
    logic signed [D_WIDTH-1:0] alpha;
    logic signed [D_WIDTH-1:0] beta;
    logic                      done;

    typedef struct {
        longint ea;
        longint eb;
        longint due;
    } exp_t;

    exp_t   sb[$];
    longint cyc;
    longint last_a;
    longint last_b;
    int     n_cmp;
    int     n_err;

    clarke_transform #(
        .D_WIDTH (D_WIDTH),
        .Q_BITS  (Q_BITS)
    ) dut (
        .clk   (clk),
        .rstb  (rstb),
        .a     (a),
        .b     (b),
        .start (start),
        .alpha (alpha),
        .beta  (beta),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp = n_cmp + 1;
        if (obs != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: K = 18919, round half up, clamp to 18-bit signed.
    function automatic longint model_beta(input longint av, input longint bv);
        longint s;
        longint p;
        longint r;
        s = av + 2 * bv;
        p = s * 18919;
        r = (p + 16384) >>> 15;
        if (r > 131071)  r = 131071;
        if (r < -131072) r = -131072;
        return r;
    endfunction

    function automatic longint rnd18();
        int unsigned r;
        r = $urandom_range(262143, 0);
        return (r >= 131072) ? longint'(r) - 262144 : longint'(r);
    endfunction

    task automatic drive(input longint av, input longint bv, input longint ea, input longint eb);
        exp_t e;
        a     = D_WIDTH'(av);
        b     = D_WIDTH'(bv);
        start = 1'b1;
        e.ea  = ea;
        e.eb  = eb;
        e.due = cyc + 3;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input longint av, input longint bv);
        drive(av, bv, av, model_beta(av, bv));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            a     = D_WIDTH'(rnd18());
            b     = D_WIDTH'(rnd18());
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: compare scoreboard entries on their due cycle and check that outputs hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rstb) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("done", longint'(done), 1);
                check("alpha", longint'(alpha), e.ea);
                check("beta", longint'(beta), e.eb);
                last_a = e.ea;
                last_b = e.eb;
            end else begin
                check("done_idle", longint'(done), 0);
                check("hold_alpha", longint'(alpha), last_a);
                check("hold_beta", longint'(beta), last_b);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        last_a = 0;
        last_b = 0;
        rstb   = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        #2;
        check("rst_done", longint'(done), 0);
        check("rst_alpha", longint'(alpha), 0);
        check("rst_beta", longint'(beta), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        idle(2);

        // Reference vectors, one at a time
        drive(27427, 3310, 27427, 19657);     idle(4);
        drive(-30376, 22970, -30376, 8986);   idle(4);
        drive(-20683, -14752, -20683, -28976); idle(4);
        drive(-32768, -32768, -32768, -56757); idle(4);

        // Same four back to back, then a bubble with held outputs
        drive(27427, 3310, 27427, 19657);
        drive(-30376, 22970, -30376, 8986);
        drive(-20683, -14752, -20683, -28976);
        drive(-32768, -32768, -32768, -56757);
        idle(6);

        // Saturation in both directions
        drive(131071, 131071, 131071, 131071);
        drive(-131072, -131072, -131072, -131072);
        idle(4);

        // Random stream with random gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(9, 0) < 7) begin
                drive_m(rnd18(), rnd18());
            end else begin
                idle(1);
            end
        end
        idle(5);

        // Reset while samples are in flight
        drive(27427, 3310, 27427, 19657);
        drive(-30376, 22970, -30376, 8986);
        drive(100, 200, 100, model_beta(100, 200));
        rstb = 1'b0;
        #1;
        check("midrst_done", longint'(done), 0);
        check("midrst_alpha", longint'(alpha), 0);
        check("midrst_beta", longint'(beta), 0);
        sb.delete();
        last_a = 0;
        last_b = 0;
        start  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        idle(4);
        drive(-20683, -14752, -20683, -28976);
        drive_m(5000, -7000);
        idle(6);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check("drain_empty", longint'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
